// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU opcode encoding and status flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_t;

  // Bit order gives status = {V,N,Z}
  typedef struct packed {
    logic v;
    logic n;
    logic z;
  } status_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the opcode, forms the result and its candidate Z/N/V flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to capture the outputs.
// Ports: a_i/b_i operands, op_i opcode, res_o result, flags_o candidate {V,N,Z}.
// Build option: ALU_STAGE_OVF_EN enables signed-overflow detection; otherwise V is tied to 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] res_o,
  output status_t          flags_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_AND:  res_o = a_i & b_i;
      ALU_NOTB: res_o = ~b_i;
      default:  res_o = '0;
    endcase
  end

  assign flags_o.z = (res_o == '0);
  assign flags_o.n = res_o[WIDTH-1];

`ifdef ALU_STAGE_OVF_EN
  logic sa, sb, sr;
  assign sa = a_i[WIDTH-1];
  assign sb = b_i[WIDTH-1];
  assign sr = res_o[WIDTH-1];

  always_comb begin
    flags_o.v = 1'b0;
    case (op_i)
      // Same-sign inputs producing a differently-signed sum
      ALU_ADD: flags_o.v = (sa == sb) && (sr != sa);
      // Opposite-sign inputs where the difference flips away from A
      ALU_SUB: flags_o.v = (sa != sb) && (sr != sa);
      default: flags_o.v = 1'b0;
    endcase
  end
`else
  assign flags_o.v = 1'b0;
`endif

endmodule

// File: rtl/alu_stage.sv
// Registered execute stage: ALU result plus Z/N/V flags behind a valid/ready register with one skid entry.
// Latency: 1 cycle from accept to c_out/out_valid; status visible the cycle after retire.
// Backpressure: in_ready is registered and drops only when both entries are full; never combinational on out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/ain/bin/alu_op/loads upstream;
//        out_valid/out_ready/c_out downstream; status = {V,N,Z}, updated on retire of a loads=1 entry.
// Build option: ALU_STAGE_OVF_EN enables the V flag (otherwise status[2] is always 0).
module alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    ain,
  input  logic [WIDTH-1:0]    bin,
  input  logic [1:0]          alu_op,
  input  logic                loads,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    c_out,
  output logic [STATUS_W-1:0] status
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b10
  } occ_t;

  occ_t             state_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Main entry drives the outputs; skid entry holds the younger result
  logic [WIDTH-1:0] main_res_q;
  logic             main_loads_q;
  status_t          main_flags_q;
  logic [WIDTH-1:0] skid_res_q;
  logic             skid_loads_q;
  status_t          skid_flags_q;
  status_t          status_q;

  logic [WIDTH-1:0] res_d;
  status_t          flags_d;
  logic             accept;
  logic             retire;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (ain),
    .b_i     (bin),
    .op_i    (alu_op_t'(alu_op)),
    .res_o   (res_d),
    .flags_o (flags_d)
  );

  assign accept = in_valid & in_ready_q;
  assign retire = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      main_res_q   <= '0;
      main_loads_q <= 1'b0;
      main_flags_q <= '0;
      skid_res_q   <= '0;
      skid_loads_q <= 1'b0;
      skid_flags_q <= '0;
      status_q     <= '0;
    end else begin
      // Flags commit from whichever entry is leaving, before it is overwritten
      if (retire && main_loads_q) begin
        status_q <= main_flags_q;
      end

      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_res_q   <= res_d;
            main_loads_q <= loads;
            main_flags_q <= flags_d;
            out_valid_q  <= 1'b1;
            state_q      <= ST_FULL1;
          end
        end

        ST_FULL1: begin
          if (accept && retire) begin
            main_res_q   <= res_d;
            main_loads_q <= loads;
            main_flags_q <= flags_d;
          end else if (accept) begin
            skid_res_q   <= res_d;
            skid_loads_q <= loads;
            skid_flags_q <= flags_d;
            in_ready_q   <= 1'b0;
            state_q      <= ST_FULL2;
          end else if (retire) begin
            out_valid_q  <= 1'b0;
            state_q      <= ST_EMPTY;
          end
        end

        ST_FULL2: begin
          if (retire) begin
            main_res_q   <= skid_res_q;
            main_loads_q <= skid_loads_q;
            main_flags_q <= skid_flags_q;
            in_ready_q   <= 1'b1;
            state_q      <= ST_FULL1;
          end
        end

        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c_out     = main_res_q;
  assign status    = status_q;

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

`ifdef ALU_STAGE_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [1:0]  alu_op;
  logic        loads;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_out;
  logic [2:0]  status;

  int checks   = 0;
  int failures = 0;

  alu_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .alu_op    (alu_op),
    .loads     (loads),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ld;
    logic [15:0] exp_c;
    logic [2:0]  exp_st;  // status after this entry retires, {V,N,Z}
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ld);
    in_valid = v;
    alu_op   = op;
    ain      = a;
    bin      = b;
    loads    = ld;
  endtask

  initial begin
    vecs[0] = '{2'b00, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, {OVF, 1'b1, 1'b0}};
    vecs[1] = '{2'b01, 16'h0005, 16'h0005, 1'b1, 16'h0000, 3'b001};
    vecs[2] = '{2'b01, 16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b001};
    vecs[3] = '{2'b11, 16'h1234, 16'h00F0, 1'b0, 16'hFF0F, 3'b001};
    vecs[4] = '{2'b10, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 3'b000};
    vecs[5] = '{2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, {OVF, 1'b0, 1'b0}};
    vecs[6] = '{2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 3'b001};
    vecs[7] = '{2'b11, 16'hAAAA, 16'h0000, 1'b1, 16'hFFFF, 3'b010};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_c_out", c_out, 0);
    chk("reset_status", status, 0);
    rst_n = 1'b1;
    tick();

    // Table: one op at a time, accept then retire, status checked afterwards
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ld);
      tick();
      drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_c_out", i), c_out, vecs[i].exp_c);
      tick();
      chk($sformatf("vec%0d_status", i), status, vecs[i].exp_st);
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Backpressure: three ops with out_ready low, loads=0 so status holds 010
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b0);
    tick();
    chk("bp_op1_valid", out_valid, 1);
    chk("bp_op1_c", c_out, 16'h0002);
    chk("bp_ready_after_op1", in_ready, 1);
    drive(1'b1, 2'b00, 16'h0002, 16'h0002, 1'b0);
    tick();
    chk("bp_ready_after_op2", in_ready, 0);
    chk("bp_c_stable1", c_out, 16'h0002);
    drive(1'b1, 2'b00, 16'h0003, 16'h0003, 1'b0);
    tick();
    chk("bp_ready_held", in_ready, 0);
    chk("bp_c_stable2", c_out, 16'h0002);
    out_ready = 1'b1;
    tick();
    chk("bp_retire2_c", c_out, 16'h0004);
    chk("bp_retire2_valid", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    chk("bp_retire3_c", c_out, 16'h0006);
    chk("bp_retire3_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_status_held", status, 3'b010);

    // Streaming: 8 ops back to back, one result per cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b00, 16'h0100, 16'(k), 1'b0);
      tick();
      chk($sformatf("stream%0d_in_ready", k), in_ready, 1);
      chk($sformatf("stream%0d_valid", k), out_valid, 1);
      chk($sformatf("stream%0d_c", k), c_out, 16'h0100 + 16'(k));
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    tick();
    chk("stream_drained", out_valid, 0);

    // Reset while both entries are full
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0010, 16'h0001, 1'b1);
    tick();
    drive(1'b1, 2'b00, 16'h0020, 16'h0001, 1'b1);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    chk("full2_in_ready", in_ready, 0);
    chk("full2_status_pre", status, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_status", status, 0);
    chk("rst_mid_c_out", c_out, 0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_idle", out_valid, 0);
    drive(1'b1, 2'b01, 16'h0000, 16'h0001, 1'b1);
    tick();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    chk("post_rst_c", c_out, 16'hFFFF);
    chk("post_rst_valid", out_valid, 1);
    tick();
    chk("post_rst_status", status, 3'b010);
    chk("post_rst_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
